// File: rtl/polaris_uart_core.sv
// Parametrised UART core: TX/RX FIFOs, configurable frame format, RX error capture.
// polaris_uart_fifo is the shared first-word-fall-through FIFO used for both directions.

module polaris_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             pop_ok;
  logic             push_ok;

  // A pop frees a slot, so a push into a full FIFO succeeds only alongside a real pop
  assign pop_ok  = pop_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pop_ok);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
endmodule

module polaris_uart_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 uart_clk_i,
  input  logic                 uart_rst_i,
  input  logic [DIV_W-1:0]     clktobaudrate,
  input  logic                 tx_en,
  input  logic                 rx_en,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 tx_fifo_en_i,
  input  logic [DATA_BITS-1:0] tx_fifo_en_data_i,
  input  logic                 rx_fifo_de_i,
  output logic [DATA_BITS-1:0] rx_fifo_de_data_o,
  output logic                 rx_head_perr_o,
  output logic                 rx_head_ferr_o,
  output logic                 tx_fifo_full,
  output logic                 tx_fifo_empty,
  output logic                 rx_fifo_full,
  output logic                 rx_fifo_empty,
  output logic [LW-1:0]        tx_level_o,
  output logic [LW-1:0]        rx_level_o,
  output logic                 rx_overrun_o,
  input  logic                 err_clr_i,
  output logic                 tx_idle_o,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o
);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned RXW  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  logic [DIV_W-1:0]     div_eff;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_pop;
  logic                 tx_expire;
  logic                 tx_last_stop;
  logic [RXW-1:0]       rx_head;
  logic                 rx_push;
  logic                 rx_expire;
  logic                 rx_fall;
  logic                 overrun_set;

  tx_state_e            tx_state_q;
  logic [DIV_W-1:0]     tx_cnt_q;
  logic [DIV_W-1:0]     tx_div_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_en_q;
  logic                 tx_two_q;
  logic                 tx_par_bit_q;
  logic                 tx_q;

  rx_state_e            rx_state_q;
  logic [DIV_W-1:0]     rx_cnt_q;
  logic [DIV_W-1:0]     rx_div_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_en_q;
  logic                 rx_odd_q;
  logic                 rx_perr_q;
  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic                 rx_prev_q;
  logic                 overrun_q;

  assign div_eff = (clktobaudrate < DIV_W'(4)) ? DIV_W'(4) : clktobaudrate;

  polaris_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk_i(uart_clk_i), .rst_i(uart_rst_i),
    .push_i(tx_fifo_en_i), .push_data_i(tx_fifo_en_data_i), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_fifo_full), .empty_o(tx_fifo_empty), .level_o(tx_level_o)
  );

  polaris_uart_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk_i(uart_clk_i), .rst_i(uart_rst_i),
    .push_i(rx_push), .push_data_i({~rx_sync_q, rx_perr_q, rx_shift_q}), .pop_i(rx_fifo_de_i),
    .head_o(rx_head), .full_o(rx_fifo_full), .empty_o(rx_fifo_empty), .level_o(rx_level_o)
  );

  // Popping at the end of the last stop bit chains frames with no idle gap
  assign tx_expire    = (tx_cnt_q == DIV_W'(1));
  assign tx_last_stop = tx_expire & ((tx_state_q == TX_STOP2) ||
                                     ((tx_state_q == TX_STOP1) && !tx_two_q));
  assign tx_pop       = tx_en & ~tx_fifo_empty & ((tx_state_q == TX_IDLE) | tx_last_stop);

  always_ff @(posedge uart_clk_i) begin
    if (uart_rst_i) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_div_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_en_q  <= 1'b0;
      tx_two_q     <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_q         <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q   <= TX_START;
      tx_cnt_q     <= div_eff;
      tx_div_q     <= div_eff;
      tx_shift_q   <= tx_head;
      tx_par_en_q  <= parity_en;
      tx_two_q     <= two_stop;
      tx_par_bit_q <= (^tx_head) ^ parity_odd;
      tx_q         <= 1'b0;
    end else if (tx_state_q == TX_IDLE) begin
      tx_q <= 1'b1;
    end else if (!tx_expire) begin
      tx_cnt_q <= tx_cnt_q - DIV_W'(1);
    end else begin
      tx_cnt_q <= tx_div_q;
      case (tx_state_q)
        TX_START: begin
          tx_state_q <= TX_DATA;
          tx_bit_q   <= '0;
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end
        TX_DATA: begin
          if (tx_bit_q == BW'(DATA_BITS - 1)) begin
            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP1;
            tx_q       <= tx_par_en_q ? tx_par_bit_q : 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + BW'(1);
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end
        TX_PARITY: begin
          tx_state_q <= TX_STOP1;
          tx_q       <= 1'b1;
        end
        TX_STOP1: tx_state_q <= tx_two_q ? TX_STOP2 : TX_IDLE;
        default:  tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign rx_expire   = (rx_cnt_q == DIV_W'(1));
  assign rx_fall     = rx_prev_q & ~rx_sync_q;
  assign rx_push     = (rx_state_q == RX_STOP) & rx_expire & rx_en;
  assign overrun_set = rx_push & rx_fifo_full & ~rx_fifo_de_i;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge uart_clk_i) begin
    if (uart_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (overrun_set)    overrun_q <= 1'b1;
      else if (err_clr_i) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge uart_clk_i) begin
    if (uart_rst_i) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q  <= RX_START;
            rx_cnt_q    <= div_eff >> 1;
            rx_div_q    <= div_eff;
            rx_par_en_q <= parity_en;
            rx_odd_q    <= parity_odd;
            rx_perr_q   <= 1'b0;
          end
        end
        RX_START: begin
          if (!rx_expire) begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end else if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= rx_div_q;
            rx_bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (!rx_expire) begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end else begin
            rx_cnt_q   <= rx_div_q;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BW'(DATA_BITS - 1)) begin
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (!rx_expire) begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end else begin
            rx_cnt_q   <= rx_div_q;
            rx_perr_q  <= rx_sync_q ^ (^rx_shift_q) ^ rx_odd_q;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!rx_expire) begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end else begin
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        default: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_fifo_de_data_o = rx_head[DATA_BITS-1:0];
  assign rx_head_perr_o    = rx_head[DATA_BITS];
  assign rx_head_ferr_o    = rx_head[DATA_BITS+1];
  assign rx_overrun_o      = overrun_q;
  assign tx_idle_o         = (tx_state_q == TX_IDLE) & tx_fifo_empty;
  assign uart_tx_o         = tx_q;
endmodule

// File: tb/tb_polaris_uart_core.sv
// Directed bench for polaris_uart_core: TX waveform, loopback, RX errors, overrun, glitch, reset.

module tb_polaris_uart_core;
  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned LW    = 3;
  localparam int unsigned BT    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic             tx_en, rx_en, par_en, par_odd, two_stop;
  logic             tx_push;
  logic [DB-1:0]    tx_data;
  logic             rx_pop;
  logic [DB-1:0]    rx_data;
  logic             rx_perr, rx_ferr;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]    tx_level, rx_level;
  logic             overrun, err_clr, tx_idle;
  logic             rx_line, tx_line;
  logic             rx_drv, loop;

  int checks   = 0;
  int failures = 0;

  assign rx_line = loop ? tx_line : rx_drv;

  polaris_uart_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .uart_clk_i(clk), .uart_rst_i(rst), .clktobaudrate(div),
    .tx_en(tx_en), .rx_en(rx_en), .parity_en(par_en), .parity_odd(par_odd), .two_stop(two_stop),
    .tx_fifo_en_i(tx_push), .tx_fifo_en_data_i(tx_data),
    .rx_fifo_de_i(rx_pop), .rx_fifo_de_data_o(rx_data),
    .rx_head_perr_o(rx_perr), .rx_head_ferr_o(rx_ferr),
    .tx_fifo_full(tx_full), .tx_fifo_empty(tx_empty),
    .rx_fifo_full(rx_full), .rx_fifo_empty(rx_empty),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .rx_overrun_o(overrun), .err_clr_i(err_clr), .tx_idle_o(tx_idle),
    .uart_rx_i(rx_line), .uart_tx_o(tx_line)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_push = 1'b1;
    tx_data = d;
    tick();
    tx_push = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check_eq({tag, "_data"}, 32'(rx_data), 32'(d));
    check_eq({tag, "_perr"}, 32'(rx_perr), 32'(pe));
    check_eq({tag, "_ferr"}, 32'(rx_ferr), 32'(fe));
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  // Samples every cycle of each bit cell and compares the whole cell at once
  task automatic expect_tx_frame(input string tag, input logic [7:0] d, input logic pe,
                                 input logic odd, input logic two);
    logic [11:0] seq;
    logic [15:0] v;
    int nb;
    seq    = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = d[i];
    nb = 9;
    if (pe) begin
      seq[nb] = (^d) ^ odd;
      nb++;
    end
    seq[nb] = 1'b1;
    nb++;
    if (two) begin
      seq[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < int'(BT); j++) begin
        v[j] = tx_line;
        tick();
      end
      check_eq($sformatf("%s_bit%0d", tag, b), 32'(v), seq[b] ? 32'h0000_ffff : 32'h0);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
    rx_drv = 1'b0;
    repeat (BT) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BT) tick();
    end
    if (pe) begin
      rx_drv = pb;
      repeat (BT) tick();
    end
    rx_drv = sb;
    repeat (BT) tick();
  endtask

  initial begin
    rst = 1'b1; div = DIV_W'(BT);
    tx_en = 1'b0; rx_en = 1'b0; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    tx_push = 1'b0; tx_data = '0; rx_pop = 1'b0; err_clr = 1'b0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) tick();
    check_eq("rst_tx_line", 32'(tx_line), 32'd1);
    check_eq("rst_tx_level", 32'(tx_level), 32'd0);
    check_eq("rst_rx_level", 32'(rx_level), 32'd0);
    check_eq("rst_empties", 32'({tx_empty, rx_empty}), 32'h3);
    check_eq("rst_fulls", 32'({tx_full, rx_full}), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_tx_idle", 32'(tx_idle), 32'd1);
    rst = 1'b0;
    tick();

    // 8N1 0xA5 waveform
    push_tx(8'hA5);
    check_eq("t1_level", 32'(tx_level), 32'd1);
    check_eq("t1_not_idle", 32'(tx_idle), 32'd0);
    tx_en = 1'b1;
    tick();
    expect_tx_frame("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("t1_idle_after", 32'(tx_idle), 32'd1);
    check_eq("t1_level_after", 32'(tx_level), 32'd0);

    // 8E2 loopback, three back-to-back frames
    loop = 1'b1; rx_en = 1'b1; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b1; tx_en = 1'b0;
    push_tx(8'h00);
    push_tx(8'hFF);
    push_tx(8'h3C);
    check_eq("t2_tx_level", 32'(tx_level), 32'd3);
    tx_en = 1'b1;
    tick();
    expect_tx_frame("t2a", 8'h00, 1'b1, 1'b0, 1'b1);
    expect_tx_frame("t2b", 8'hFF, 1'b1, 1'b0, 1'b1);
    expect_tx_frame("t2c", 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (5) tick();
    check_eq("t2_rx_level", 32'(rx_level), 32'd3);
    pop_check("t2_h0", 8'h00, 1'b0, 1'b0);
    pop_check("t2_h1", 8'hFF, 1'b0, 1'b0);
    pop_check("t2_h2", 8'h3C, 1'b0, 1'b0);
    check_eq("t2_rx_empty", 32'(rx_empty), 32'd1);
    loop = 1'b0;

    // 8O1 parity error, frame error, re-arm after line high
    par_en = 1'b1; par_odd = 1'b1; two_stop = 1'b0;
    repeat (4) tick();
    send_rx(8'h55, 1'b1, 1'b0, 1'b1);
    repeat (20) tick();
    send_rx(8'h0F, 1'b1, 1'b1, 1'b0);
    repeat (48) tick();
    check_eq("t3_level_low", 32'(rx_level), 32'd2);
    rx_drv = 1'b1;
    repeat (20) tick();
    send_rx(8'h81, 1'b1, 1'b1, 1'b1);
    repeat (20) tick();
    check_eq("t3_level", 32'(rx_level), 32'd3);
    pop_check("t3_h0", 8'h55, 1'b1, 1'b0);
    pop_check("t3_h1", 8'h0F, 1'b0, 1'b1);
    pop_check("t3_h2", 8'h81, 1'b0, 1'b0);

    // RX overrun with DEPTH=4, clear, then accept during pop
    par_en = 1'b0;
    send_rx(8'h11, 1'b0, 1'b0, 1'b1); repeat (20) tick();
    send_rx(8'h22, 1'b0, 1'b0, 1'b1); repeat (20) tick();
    send_rx(8'h33, 1'b0, 1'b0, 1'b1); repeat (20) tick();
    send_rx(8'h44, 1'b0, 1'b0, 1'b1); repeat (20) tick();
    check_eq("t4_full", 32'(rx_full), 32'd1);
    check_eq("t4_level4", 32'(rx_level), 32'd4);
    check_eq("t4_no_ovr", 32'(overrun), 32'd0);
    send_rx(8'h55, 1'b0, 1'b0, 1'b1); repeat (20) tick();
    check_eq("t4_ovr", 32'(overrun), 32'd1);
    check_eq("t4_level_ovr", 32'(rx_level), 32'd4);
    check_eq("t4_head", 32'(rx_data), 32'h11);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("t4_ovr_clr", 32'(overrun), 32'd0);
    // Stop sample lands 155 cycles after the start bit is driven
    fork
      send_rx(8'h66, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) tick();
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
      end
    join
    repeat (20) tick();
    check_eq("t4_ovr_pop", 32'(overrun), 32'd0);
    check_eq("t4_level_pop", 32'(rx_level), 32'd4);
    pop_check("t4_h0", 8'h22, 1'b0, 1'b0);
    pop_check("t4_h1", 8'h33, 1'b0, 1'b0);
    pop_check("t4_h2", 8'h44, 1'b0, 1'b0);
    pop_check("t4_h3", 8'h66, 1'b0, 1'b0);
    check_eq("t4_empty", 32'(rx_empty), 32'd1);

    // Short low glitch is a false start
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (40) tick();
    check_eq("t5_glitch_level", 32'(rx_level), 32'd0);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (20) tick();
    check_eq("t5_rx_level", 32'(rx_level), 32'd1);
    check_eq("t5_rx_head", 32'(rx_data), 32'h5A);

    // TX push while full with simultaneous pop
    tx_en = 1'b0;
    push_tx(8'hA1);
    push_tx(8'hB2);
    push_tx(8'hC3);
    push_tx(8'hD4);
    check_eq("t5_tx_full", 32'(tx_full), 32'd1);
    check_eq("t5_tx_level", 32'(tx_level), 32'd4);
    tx_push = 1'b1;
    tx_data = 8'hE5;
    tx_en   = 1'b1;
    tick();
    tx_push = 1'b0;
    check_eq("t5_tx_level_pp", 32'(tx_level), 32'd4);
    expect_tx_frame("t5a", 8'hA1, 1'b0, 1'b0, 1'b0);
    expect_tx_frame("t5b", 8'hB2, 1'b0, 1'b0, 1'b0);
    expect_tx_frame("t5c", 8'hC3, 1'b0, 1'b0, 1'b0);
    expect_tx_frame("t5d", 8'hD4, 1'b0, 1'b0, 1'b0);
    expect_tx_frame("t5e", 8'hE5, 1'b0, 1'b0, 1'b0);
    check_eq("t5_tx_idle", 32'(tx_idle), 32'd1);

    // Reset in the middle of a data bit
    tx_en = 1'b0;
    push_tx(8'h00);
    push_tx(8'h00);
    tx_en = 1'b1;
    tick();
    repeat (BT + BT + 4) tick();
    check_eq("t6_pre_line", 32'(tx_line), 32'd0);
    check_eq("t6_pre_level", 32'(tx_level), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("t6_line", 32'(tx_line), 32'd1);
    check_eq("t6_tx_level", 32'(tx_level), 32'd0);
    check_eq("t6_rx_level", 32'(rx_level), 32'd0);
    check_eq("t6_empties", 32'({tx_empty, rx_empty}), 32'h3);
    check_eq("t6_fulls", 32'({tx_full, rx_full}), 32'h0);
    check_eq("t6_idle", 32'(tx_idle), 32'd1);
    rst = 1'b0;
    tx_en = 1'b0;
    tick();
    push_tx(8'hC3);
    tx_en = 1'b1;
    tick();
    expect_tx_frame("t6", 8'hC3, 1'b0, 1'b0, 1'b0);
    check_eq("t6_idle_after", 32'(tx_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/polaris_uart_core.md
Name: polaris_uart_core

Overview:
Parametrised next-generation UART with configurable frame format (data width, optional parity, 1/2 stop bits) and configurable FIFO depth. Adds receive error reporting (frame, parity, overrun), FIFO fill levels and a TX-idle indication. Sits behind the TileLink UART register front-end; a single clock domain drives it, and `uart_rx_i` is asynchronous.

Parameters:
- DATA_BITS, 8, character width; legal 5..8; sent LSB first.
- FIFO_DEPTH, 32, entries per TX/RX FIFO; power of 2, ≥2.
- DIV_W, 16, width of baud divisor.
- LW, $clog2(FIFO_DEPTH)+1, level port width (derived).

Ports:
- uart_clk_i  in  1  clock
- uart_rst_i  in  1  synchronous active-high reset
- clktobaudrate  in  DIV_W  clocks per bit; values <4 treated as 4
- tx_en  in  1  allow TX FIFO drain
- rx_en  in  1  allow RX FIFO fill
- parity_en  in  1  parity bit present
- parity_odd  in  1  1=odd, 0=even
- two_stop  in  1  TX sends 2 stop bits; RX checks first only
- tx_fifo_en_i  in  1  push TX byte
- tx_fifo_en_data_i  in  DATA_BITS  TX data
- rx_fifo_de_i  in  1  pop RX head
- rx_fifo_de_data_o  out  DATA_BITS  RX head data (first-word fall-through)
- rx_head_perr_o  out  1  parity error flag of head entry
- rx_head_ferr_o  out  1  frame error flag of head entry
- tx_fifo_full / tx_fifo_empty / rx_fifo_full / rx_fifo_empty  out  1 each
- tx_level_o / rx_level_o  out  LW  entries held
- rx_overrun_o  out  1  sticky; received character dropped because RX FIFO was full
- err_clr_i  in  1  clears rx_overrun_o
- tx_idle_o  out  1  TX FIFO empty and shifter idle
- uart_rx_i  in  1  serial in
- uart_tx_o  out  1  serial out

Behaviour:
- Reset (sync, active high):
  - uart_tx_o=1.
  - FIFOs empty: levels 0, empty flags=1, full flags=0.
  - rx_overrun_o=0; tx_idle_o=1.
  - TX and RX FSMs in IDLE; baud counters cleared.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 the next cycle.
- FIFOs:
  - Push when full is ignored, unless a pop occurs in the same cycle, in which case both are performed.
  - Pop when empty is ignored.
  - Simultaneous push and pop on empty: the push takes effect; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Level updates the cycle after the push/pop.
  - RX entry is {ferr, perr, data}.
- TX FSM states IDLE→START→DATA→PARITY→STOP1→STOP2→IDLE:
  - Each state lasts exactly clktobaudrate cycles.
  - PARITY is skipped if !parity_en; STOP2 is skipped if !two_stop.
  - In IDLE, with tx_en & !tx_fifo_empty: pop the head into the shifter, and drive uart_tx_o=0 the next cycle.
  - Back-to-back characters have no idle gap.
  - Parity bit = XOR(data) ^ parity_odd.
  - tx_en deasserted mid-frame: the current frame completes, and no new pop occurs.
- RX input and FSM states IDLE→START→DATA→PARITY→STOP→IDLE:
  - uart_rx_i passes through a 2-flop synchroniser; edge detection uses the synchronised value.
  - IDLE: a falling edge enters START and loads the counter with clktobaudrate/2.
  - START: at expiry (mid start bit), if the line is high it is a false start → IDLE with no push. Otherwise the counter reloads clktobaudrate and the FSM samples each later bit at mid-bit.
  - perr = received parity ≠ XOR(data)^parity_odd (0 if !parity_en).
  - ferr = stop sample is 0.
  - At the STOP sample, if rx_en: push {ferr,perr,data}, or, if full and not popping that cycle, drop the character and set rx_overrun_o.
  - After a ferr, the FSM waits for the line to go high before re-arming.
- rx_overrun_o: err_clr_i clears it. If err_clr_i and a new overrun occur in the same cycle, set wins.
- Configuration inputs (divisor, parity_en, parity_odd, two_stop) are sampled at frame start; changes mid-frame have no effect on that frame.

Test Plan:
- Divisor=16, 8N1, push 0xA5 → uart_tx_o low 16 cycles, then bits 1,0,1,0,0,1,0,1 of 16 cycles each, then high 16 cycles; tx_idle_o=1 after the stop bit.
- Loopback tx→rx, 8E2, push 0x00,0xFF,0x3C back to back → rx_level_o=3; head values 0x00,0xFF,0x3C with perr=ferr=0; TX frame is 12 bit-times with no inter-frame gap.
- Inject 0x55 with wrong parity (8O1), then a frame with stop=0 → head0 perr=1; head1 ferr=1, and RX re-arms only after the line returns high.
- Fill RX (FIFO_DEPTH=4) with 5 characters and no pops → rx_fifo_full=1, the 5th is dropped, rx_overrun_o=1; err_clr_i → 0. A character that completes during a pop is accepted.
- Low glitch of 3 cycles at divisor=16 → no push, RX back to IDLE; TX push while full with a simultaneous pop → level unchanged, data order preserved.
- Assert uart_rst_i mid-TX data bit → next cycle uart_tx_o=1, levels 0, flags reset; a later push transmits normally.
